uart_mem_loader: RTL

Byte-stream loader directly downstream of the UART receiver. It consumes received bytes over a valid/ready handshake and parses a small packet protocol. WRITE packets become 32-bit word writes on a req/gnt memory port. GO packets publish a boot address with a start pulse. It is the path by which program images are loaded over UART into on-chip memory before the core is released.

---
 rtl/uart_mem_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_mem_loader.sv
// UART byte-stream packet loader: parses WRITE packets into 32-bit word writes
// on a req/gnt memory port and GO packets into a boot address with a start pulse.
module uart_mem_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
   parameter logic [31:0] BOOT_ADDR_RST  = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        done_o,
   output logic        err_o,
   output logic        go_o,
   output logic [31:0] boot_addr_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_WRITE, S_CSUM, S_GOADDR
   } state_t;

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

   state_t      r_state;
   logic [1:0]  r_byte_cnt;
   logic [23:0] r_shift;
   logic [15:0] r_words;
   logic [7:0]  r_csum;
   logic [31:0] r_to_cnt;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_done;
   logic        r_err;
   logic        r_go;
   logic [31:0] r_boot_addr;

   logic        w_rx_ready;
   logic        w_accept;
   logic        w_to_active;
   logic        w_timeout;
   logic [31:0] w_word;

   // Fields arrive LSB first, so each new byte enters at the top of the word.
   assign w_word      = {rx_data_i, r_shift};
   assign w_rx_ready  = (r_state != S_WRITE);
   assign w_accept    = rx_valid_i && w_rx_ready;
   assign w_to_active = (r_state != S_IDLE) && (r_state != S_WRITE);
   assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_to_active && !w_accept &&
                        (r_to_cnt == TO_LAST);

   // NOTE: all state lives in this one clocked block and uses non-blocking
   // assignments only, so every branch sees the pre-edge values of the others.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_byte_cnt  <= 2'd0;
         r_shift     <= 24'd0;
         r_words     <= 16'd0;
         r_csum      <= 8'd0;
         r_to_cnt    <= 32'd0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_go        <= 1'b0;
         r_boot_addr <= BOOT_ADDR_RST;
      end else begin
         r_done <= 1'b0;
         r_go   <= 1'b0;

         if (w_accept || w_timeout || !w_to_active) r_to_cnt <= 32'd0;
         else                                       r_to_cnt <= r_to_cnt + 32'd1;

         if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept && rx_data_i == 8'hA5) begin
                     r_err   <= 1'b0;
                     r_state <= S_CMD;
                  end
               end
               S_CMD: begin
                  if (w_accept) begin
                     r_byte_cnt <= 2'd0;
                     r_csum     <= 8'd0;
                     case (rx_data_i)
                        8'h01:   r_state <= S_ADDR;
                        8'h02:   r_state <= S_GOADDR;
                        default: begin
                           r_err   <= 1'b1;
                           r_state <= S_IDLE;
                        end
                     endcase
                  end
               end
               S_ADDR: begin
                  if (w_accept) begin
                     r_shift    <= w_word[31:8];
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                     if (r_byte_cnt == 2'd3) begin
                        r_mem_addr <= {w_word[31:2], 2'b00};
                        r_state    <= S_LEN;
                     end
                  end
               end
               S_LEN: begin
                  if (w_accept) begin
                     r_shift    <= w_word[31:8];
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                     if (r_byte_cnt[0]) begin
                        r_byte_cnt <= 2'd0;
                        r_words    <= w_word[31:16];
                        r_state    <= (w_word[31:16] != 16'd0) ? S_DATA : S_CSUM;
                     end
                  end
               end
               S_DATA: begin
                  if (w_accept) begin
                     r_shift    <= w_word[31:8];
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                     r_csum     <= r_csum + rx_data_i;
                     if (r_byte_cnt == 2'd3) begin
                        r_mem_wdata <= w_word;
                        r_state     <= S_WRITE;
                     end
                  end
               end
               S_WRITE: begin
                  if (mem_gnt_i) begin
                     r_mem_addr <= r_mem_addr + 32'd4;
                     r_words    <= r_words - 16'd1;
                     r_state    <= (r_words == 16'd1) ? S_CSUM : S_DATA;
                  end
               end
               S_CSUM: begin
                  if (w_accept) begin
                     if (rx_data_i == r_csum) r_done <= 1'b1;
                     else                     r_err  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
               S_GOADDR: begin
                  if (w_accept) begin
                     r_shift    <= w_word[31:8];
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                     if (r_byte_cnt == 2'd3) begin
                        r_boot_addr <= {w_word[31:2], 2'b00};
                        r_go        <= 1'b1;
                        r_state     <= S_IDLE;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign rx_ready_o  = w_rx_ready;
   assign mem_req_o   = (r_state == S_WRITE);
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign go_o        = r_go;
   assign boot_addr_o = r_boot_addr;

endmodule
